imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Write-side initiator for the word-aligned instruction/data RAMs: receives a
//   byte stream over a valid/ready handshake, packs 4 bytes little-endian into
//   32-bit words, and issues one write pulse per word on a we/a/wd port. The
//   port drives the RAM write interface directly. It replaces $readmemh
//   preloading, so programs can be loaded at run time before the core
//   leaves reset.
// PARAMETERS
//   LOAD_WORDS  64            number of words per load (1..2**ADDR_W)
//   ADDR_W      6             word-index width; RAM depth = 2**ADDR_W
//   BASE_ADDR   32'h0000_0000 byte address of word 0 (word aligned, [1:0]=0)
// PORTS
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   start     in   1       begin a load; sampled only in IDLE or DONE
//   in_valid  in   1       in_data carries a byte
//   in_data   in   8       stream byte
//   in_ready  out  1       loader accepts a byte this cycle
//   mem_we    out  1       one-cycle write strobe to RAM
//   mem_a     out  32      byte address, BASE_ADDR + 4*word_idx
//   mem_wd    out  32      packed word
//   busy      out  1       load in progress (state != IDLE/DONE)
//   done      out  1       load complete; held until next start
//   word_cnt  out  ADDR_W+1  words written in current load
//   cks_err   out  1       (CHECKSUM_EN only) checksum mismatch, valid with done
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, all outputs 0, byte_idx=0,
//     word_idx=0, word buffer=0. A word partly assembled at reset is discarded;
//     no write is issued.
//   - States: IDLE, RECV, WRITE, [CHECK], DONE.
//   - IDLE/DONE: start=1 -> RECV, byte_idx=0, word_idx=0, word_cnt=0, done=0,
//     cks_err=0. start ignored in RECV/WRITE/CHECK.
//   - RECV: in_ready=1. Byte accepted on in_valid&in_ready; byte k (0..3)
//     -> buf[8k+7:8k]. Acceptance of byte 3 -> WRITE next cycle.
//   - WRITE (exactly 1 cycle): in_ready=0, mem_we=1,
//     mem_a=BASE_ADDR+{word_idx,2'b00}, mem_wd=buf; word_cnt increments at the
//     end of the cycle. If word_idx==LOAD_WORDS-1 -> DONE (or CHECK), else
//     word_idx++ -> RECV.
//   - mem_a/mem_wd are registered and stable only while mem_we=1; do not care
//     otherwise. Back-to-back bytes give 5 cycles per word minimum.
//   - in_valid gaps stall RECV indefinitely; no timeout.
//   - word_idx never wraps within a load; the address is truncated to ADDR_W bits.
//   - DONE: done=1, busy=0, in_ready=0; bytes offered are not consumed.
// CONFIGURATION
//   CHECKSUM_EN defined: 8-bit running sum of every data byte accepted. After
//     the last WRITE -> CHECK with in_ready=1; one more byte accepted; cks_err=1
//     if (sum+byte)[7:0]!=0, else 0; then -> DONE. cks_err has no effect on
//     RAM contents already written.
//   CHECKSUM_EN undefined: no CHECK state, no cks_err port, no sum register;
//     the last WRITE goes straight to DONE.
// TESTING
//   1 reset then start, bytes 78 56 34 12 back-to-back -> mem_we one cycle,
//     mem_a=0x0, mem_wd=0x12345678; WRITE is 4 cycles after first accept.
//   2 LOAD_WORDS=2, words 0xDEADBEEF,0x00000001 -> writes at a=0x0 and 0x4, then
//     done=1, word_cnt=2, busy=0, in_ready=0.
//   3 in_valid toggled 1/0 every cycle during a word -> same mem_wd, no dropped
//     or duplicated bytes, in_ready=0 during WRITE.
//   4 rst_n low after 2 bytes, then restart with 4 new bytes -> only one write,
//     data = new bytes only, a=0x0.
//   5 start pulsed mid-load -> ignored; start in DONE -> new load from a=0x0,
//     done clears the next cycle.
//   6 CHECKSUM_EN, LOAD_WORDS=1, bytes 01 02 03 04 then 0xF6 -> cks_err=0;
//     repeat with 0xF7 -> cks_err=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and RAM write port of the instruction-memory loader.
// master = loader side, slave = stream source / RAM side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_a, mem_wd
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to RAM.
// Optional trailing checksum byte and cks_err output when CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned LOAD_WORDS = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
`ifdef CHECKSUM_EN
  ,
  output logic              cks_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t            state_q;
  logic [1:0]        byte_idx_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [31:0]       buf_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [31:0]       mem_a_q;
  logic [31:0]       mem_wd_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W:0]   word_cnt_q;
`ifdef CHECKSUM_EN
  logic [7:0]        sum_q;
  logic              cks_err_q;
`endif

  logic accept;
  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_cnt_q <= '0;
`ifdef CHECKSUM_EN
      sum_q      <= '0;
      cks_err_q  <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_RECV;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
`ifdef CHECKSUM_EN
            sum_q      <= '0;
            cks_err_q  <= 1'b0;
`endif
          end
        end

        S_RECV: begin
          if (accept) begin
            buf_q[{byte_idx_q, 3'b000} +: 8] <= bus.in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef CHECKSUM_EN
            sum_q      <= sum_q + bus.in_data;
`endif
            // Write strobe and payload are registered here so they are valid
            // for exactly the WRITE cycle.
            if (byte_idx_q == 2'd3) begin
              state_q    <= S_WRITE;
              in_ready_q <= 1'b0;
              mem_we_q   <= 1'b1;
              mem_a_q    <= BASE_ADDR + 32'({word_idx_q, 2'b00});
              mem_wd_q   <= {bus.in_data, buf_q[23:0]};
            end
          end
        end

        S_WRITE: begin
          word_cnt_q <= word_cnt_q + 1'b1;
          if (word_idx_q == ADDR_W'(LOAD_WORDS - 1)) begin
`ifdef CHECKSUM_EN
            state_q    <= S_CHECK;
            in_ready_q <= 1'b1;
`else
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
`endif
          end else begin
            word_idx_q <= word_idx_q + 1'b1;
            state_q    <= S_RECV;
            in_ready_q <= 1'b1;
          end
        end

`ifdef CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            cks_err_q  <= 8'(sum_q + bus.in_data) != 8'h00;
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wd   = mem_wd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign word_cnt     = word_cnt_q;
`ifdef CHECKSUM_EN
  assign cks_err      = cks_err_q;
`endif

endmodule
